txn_race_ctrl: RTL and testbench

- Synthesizable sequencer for a "one serial transaction, then first-of-N race with watchdog" pattern.
- Drives a serial primary transaction on channel 0 to completion.
- Then launches channels 1..NUM_CH-1 concurrently. The first completion wins; all still-pending losers get a cancel pulse.
- A race watchdog of TIME_OUT/2 cycles cancels everything if no channel completes in time.
- Sits between the test-sequence control logic and the per-channel transaction engines.

---
 rtl/txn_race_ctrl.sv | 167 ++++++++++++++++
 tb/tb_txn_race_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/txn_race_ctrl.sv
// rtl/txn_race_ctrl.sv - serial primary transaction followed by a first-of-N race with watchdog
// Optional macro TXN_RACE_PRIMARY_WDOG_EN adds a TIME_OUT-cycle watchdog on the primary phase.
module txn_race_ctrl #(
  parameter int NUM_CH   = 3,
  parameter int TIME_OUT = 20,
  parameter int ID_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] cancel,
  output logic              busy,
  output logic              result_valid,
  output logic [ID_W-1:0]   winner_id,
  output logic              timed_out
);

  localparam int WIN   = TIME_OUT / 2;
  localparam int CNT_W = $clog2(WIN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [NUM_CH-1:0] RACE_MASK = {{(NUM_CH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIMARY,
    S_RACE,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  req_q, req_d;
  logic [NUM_CH-1:0]  cancel_q, cancel_d;
  logic               busy_q, busy_d;
  logic               rv_q, rv_d;
  logic [ID_W-1:0]    win_q, win_d;
  logic               to_q, to_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  race_hit;
  logic [ID_W-1:0]    win_idx;

`ifdef TXN_RACE_PRIMARY_WDOG_EN
  localparam int PCNT_W = $clog2(TIME_OUT + 1);
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      cancel_q <= '0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      win_q    <= '0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
`ifdef TXN_RACE_PRIMARY_WDOG_EN
      pcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cancel_q <= cancel_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      win_q    <= win_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
`ifdef TXN_RACE_PRIMARY_WDOG_EN
      pcnt_q   <= pcnt_d;
`endif
    end
  end

  // Only still-requested race channels can win; lowest index takes simultaneous completions.
  always_comb begin
    race_hit = done & req_q & RACE_MASK;
    win_idx  = '0;
    for (int i = NUM_CH - 1; i >= 1; i--) begin
      if (race_hit[i]) win_idx = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cancel_d = '0;
    busy_d   = busy_q;
    rv_d     = 1'b0;
    win_d    = win_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
`ifdef TXN_RACE_PRIMARY_WDOG_EN
    pcnt_d   = pcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = S_PRIMARY;
          req_d   = NUM_CH'(1);
          busy_d  = 1'b1;
          win_d   = '0;
          to_d    = 1'b0;
`ifdef TXN_RACE_PRIMARY_WDOG_EN
          pcnt_d  = '0;
`endif
        end
      end
      S_PRIMARY: begin
        if (done[0] && req_q[0]) begin
          state_d = S_RACE;
          req_d   = RACE_MASK;
          cnt_d   = '0;
        end
`ifdef TXN_RACE_PRIMARY_WDOG_EN
        else if (pcnt_q == PCNT_W'(TIME_OUT - 1)) begin
          state_d  = S_FINISH;
          req_d    = '0;
          cancel_d = NUM_CH'(1);
          to_d     = 1'b1;
          win_d    = '0;
          rv_d     = 1'b1;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
`endif
      end
      S_RACE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A completion in the last window cycle still beats the watchdog.
        if (|race_hit) begin
          state_d  = S_FINISH;
          req_d    = '0;
          win_d    = win_idx;
          cancel_d = RACE_MASK & ~(NUM_CH'(1) << win_idx);
          rv_d     = 1'b1;
        end else if (cnt_q == CNT_W'(WIN - 1)) begin
          state_d  = S_FINISH;
          req_d    = '0;
          win_d    = '0;
          to_d     = 1'b1;
          cancel_d = RACE_MASK;
          rv_d     = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign req          = req_q;
  assign cancel       = cancel_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign winner_id    = win_q;
  assign timed_out    = to_q;

endmodule

// File: tb/tb_txn_race_ctrl.sv
// tb/tb_txn_race_ctrl.sv - self-checking bench for txn_race_ctrl
module tb_txn_race_ctrl;

  localparam int NUM_CH   = 3;
  localparam int TIME_OUT = 20;
  localparam int WIN      = TIME_OUT / 2;
  localparam int ID_W     = $clog2(NUM_CH);
  localparam int RMASK    = (1 << NUM_CH) - 2;
`ifdef TXN_RACE_PRIMARY_WDOG_EN
  localparam bit PWDOG = 1'b1;
`else
  localparam bit PWDOG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NUM_CH-1:0] done = '0;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] cancel;
  logic              busy;
  logic              result_valid;
  logic [ID_W-1:0]   winner_id;
  logic              timed_out;

  txn_race_ctrl #(.NUM_CH(NUM_CH), .TIME_OUT(TIME_OUT), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req), .done(done),
    .cancel(cancel), .busy(busy), .result_valid(result_valid),
    .winner_id(winner_id), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int prev_w = 0, prev_to = 0;
  int dly[NUM_CH];
  int obs_f, obs_w, obs_to, obs_can;

  typedef struct {
    int dp; int d1; int d2; int gap;
    int ef; int ew; int eto; int ecan;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0d: got %0d expected %0d", nm, tag, act, exp);
    end
  endtask

  task automatic chk_zero(input int tag);
    chk("rst_req", tag, int'(req), 0);
    chk("rst_cancel", tag, int'(cancel), 0);
    chk("rst_busy", tag, int'(busy), 0);
    chk("rst_rv", tag, int'(result_valid), 0);
    chk("rst_winner", tag, int'(winner_id), 0);
    chk("rst_timed_out", tag, int'(timed_out), 0);
  endtask

  // Transaction-level reference: the whole timeline follows from the primary
  // delay dp and each race channel's completion delay measured from race start.
  task automatic run_seq(input int dp, input int gap, input bit noise, input int abort_at);
    bit pto;
    int r, dmin, f, w, to, e_req, e_can, e_w, e_to;
    logic [NUM_CH-1:0] dv;
    pto  = PWDOG && (dp >= TIME_OUT);
    r    = 2 + dp;
    dmin = 1 << 30;
    w    = 0;
    for (int i = 1; i < NUM_CH; i++) if (dly[i] < dmin) begin dmin = dly[i]; w = i; end
    if (pto) begin f = TIME_OUT + 1; w = 0; to = 1; end
    else if (dmin < WIN) begin f = r + dmin + 1; to = 0; end
    else begin f = r + WIN; w = 0; to = 1; end
    obs_f = -1; obs_w = -1; obs_to = -1; obs_can = -1;
    for (int rel = 0; rel <= f + gap; rel++) begin
      @(posedge clk); #1;
      e_req = 0;
      if (pto) begin
        if (rel >= 1 && rel < f) e_req = 1;
      end else begin
        if (rel >= 1 && rel <= 1 + dp) e_req = 1;
        if (rel >= r && rel < f) e_req = RMASK;
      end
      e_can = 0;
      if (rel == f) e_can = pto ? 1 : (RMASK & ~((w != 0) ? (1 << w) : 0));
      e_w  = (rel == 0) ? prev_w  : ((rel < f) ? 0 : w);
      e_to = (rel == 0) ? prev_to : ((rel < f) ? 0 : to);
      chk("req", rel, int'(req), e_req);
      chk("cancel", rel, int'(cancel), e_can);
      chk("busy", rel, int'(busy), int'(rel >= 1 && rel <= f));
      chk("result_valid", rel, int'(result_valid), int'(rel == f));
      chk("winner_id", rel, int'(winner_id), e_w);
      chk("timed_out", rel, int'(timed_out), e_to);
      if (result_valid && obs_f < 0) begin
        obs_f = rel; obs_w = int'(winner_id); obs_to = int'(timed_out); obs_can = int'(cancel);
      end
      start = (rel == 0) ? 1'b1 : (noise && rel <= f && $urandom_range(0, 3) == 0);
      dv = '0;
      if (!pto && rel == 1 + dp) dv[0] = 1'b1;
      if (noise && ((!pto && rel >= r) || (pto && rel >= f)) && $urandom_range(0, 2) == 0) dv[0] = 1'b1;
      for (int i = 1; i < NUM_CH; i++) begin
        if (!pto && rel == r + dly[i]) dv[i] = 1'b1;
        if (noise && (rel <= 1 + dp || rel >= f) && $urandom_range(0, 2) == 0) dv[i] = 1'b1;
      end
      done = dv;
      if (rel == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero(rel);
        repeat (3) begin
          @(posedge clk); #1;
          chk_zero(rel);
        end
        start = 1'b0; done = '0; rst_n = 1'b1;
        prev_w = 0; prev_to = 0;
        return;
      end
    end
    prev_w = w; prev_to = to;
  endtask

  initial begin
    tbl[0] = '{3, 99,  3, 0,  9, 2, 0, 2};
    tbl[1] = '{3,  2,  2, 0,  8, 1, 0, 4};
    tbl[2] = '{3, 99, 99, 0, 15, 0, 1, 6};
    tbl[3] = '{3,  9, 99, 1, 15, 1, 0, 4};
    tbl[4] = '{0,  0, 99, 0,  3, 1, 0, 4};
    tbl[5] = '{3, 10, 12, 2, 15, 0, 1, 6};

    #12 chk_zero(-1);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_zero(-2);

    for (int t = 0; t < 6; t++) begin
      dly[0] = 0; dly[1] = tbl[t].d1; dly[2] = tbl[t].d2;
      run_seq(tbl[t].dp, tbl[t].gap, 1'b1, -1);
      chk("tbl_finish_cycle", t, obs_f, tbl[t].ef);
      chk("tbl_winner", t, obs_w, tbl[t].ew);
      chk("tbl_timed_out", t, obs_to, tbl[t].eto);
      chk("tbl_cancel", t, obs_can, tbl[t].ecan);
    end

    dly[0] = 0; dly[1] = 99; dly[2] = 3;
    run_seq(3, 0, 1'b1, 7);
    run_seq(3, 0, 1'b0, -1);
    chk("post_reset_finish", 0, obs_f, 9);
    chk("post_reset_cancel", 0, obs_can, 2);

    dly[1] = 1; dly[2] = 99;
    run_seq(24, 0, 1'b1, -1);
`ifdef TXN_RACE_PRIMARY_WDOG_EN
    chk("wdog_finish", 0, obs_f, 21);
    chk("wdog_cancel", 0, obs_can, 1);
    chk("wdog_timed_out", 0, obs_to, 1);
`else
    chk("long_primary_finish", 0, obs_f, 28);
    chk("long_primary_cancel", 0, obs_can, 4);
    chk("long_primary_winner", 0, obs_w, 1);
`endif

    for (int n = 0; n < 40; n++) begin
      dly[0] = 0;
      for (int i = 1; i < NUM_CH; i++) dly[i] = $urandom_range(0, 13);
      run_seq(($urandom_range(0, 5) == 0) ? $urandom_range(15, 25) : $urandom_range(0, 6),
              $urandom_range(0, 2), 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
